// File: rtl/uart_tx_engine_if.sv
// Host-side handshake and serial line of the UART transmit engine.
// master: the host driving load/din; slave: the transmit engine.
interface uart_tx_engine_if;
   logic       load;
   logic [7:0] din;
   logic       tx;
   logic       txrdy;
   logic       busy;
   logic       done;

   modport master (
      output load,
      output din,
      input  tx,
      input  txrdy,
      input  busy,
      input  done
   );

   modport slave (
      input  load,
      input  din,
      output tx,
      output txrdy,
      output busy,
      output done
   );
endinterface

// File: rtl/uart_tx_engine.sv
// UART transmit engine: accepts a byte and emits start bit, 8 data bits
// LSB-first, optional parity, stop bit. Every bit is held BIT_TIME clocks.
// The serial line is bit 0 of the frame shift register, so it is registered
// and idles at 1 because the register is refilled with 1s while shifting.
module uart_tx_engine #(
   parameter int unsigned BIT_TIME = 10416,
   parameter bit          PAR_EN   = 1'b0,
   parameter bit          PAR_ODD  = 1'b0
) (
   input logic            clk,
   input logic            reset,
   uart_tx_engine_if.slave bus
);

   localparam int unsigned FRAME    = PAR_EN ? 11 : 10;
   localparam logic [15:0] BaudLast = 16'(BIT_TIME - 1);
   localparam logic [3:0]  BitLast  = 4'(FRAME - 1);

   typedef enum logic [0:0] {StIdle, StSend} state_e;

   state_e      state_q;
   logic [15:0] baud_cnt_q;
   logic [3:0]  bit_cnt_q;
   logic [10:0] shreg_q;
   logic        txrdy_q;
   logic        busy_q;
   logic        done_q;

   logic        parity;
   logic [10:0] frame_load;
   logic        accept;
   logic        bit_end;

   // Frame image for the byte on din plus accept/bit-boundary decodes.
   always_comb begin
      parity = (^bus.din) ^ PAR_ODD;
      // Without parity the unused top bit is a second stop-level 1, never sent.
      if (PAR_EN) begin
         frame_load = {1'b1, parity, bus.din, 1'b0};
      end else begin
         frame_load = {2'b11, bus.din, 1'b0};
      end
      accept  = bus.load && txrdy_q;
      bit_end = (baud_cnt_q == BaudLast);
   end

   // Frame sequencer: accept, baud timing, shifting and end-of-frame signalling.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StIdle;
         baud_cnt_q <= '0;
         bit_cnt_q  <= '0;
         shreg_q    <= '1;
         txrdy_q    <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            StIdle: begin
               if (accept) begin
                  state_q    <= StSend;
                  shreg_q    <= frame_load;
                  txrdy_q    <= 1'b0;
                  busy_q     <= 1'b1;
                  baud_cnt_q <= '0;
                  bit_cnt_q  <= '0;
               end
            end
            StSend: begin
               if (bit_end) begin
                  baud_cnt_q <= '0;
                  shreg_q    <= {1'b1, shreg_q[10:1]};
                  if (bit_cnt_q == BitLast) begin
                     // Stop bit finished; line already 1 and stays 1.
                     state_q   <= StIdle;
                     bit_cnt_q <= '0;
                     done_q    <= 1'b1;
                     txrdy_q   <= 1'b1;
                     busy_q    <= 1'b0;
                  end else begin
                     bit_cnt_q <= bit_cnt_q + 4'd1;
                  end
               end else begin
                  baud_cnt_q <= baud_cnt_q + 16'd1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.tx    = shreg_q[0];
   assign bus.txrdy = txrdy_q;
   assign bus.busy  = busy_q;
   assign bus.done  = done_q;

endmodule
